// File: rtl/atomic_read_arbiter_if.sv
// Bus bundle between the read arbiter, its requesters and the 64-bit event counter's 32-bit read port.
// The arbiter connects through the slave modport; the environment drives it through master.
interface atomic_read_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int GNT_W = $clog2(NUM_REQ);

  // Requester side
  logic [NUM_REQ-1:0] rd_req_i;
  logic [NUM_REQ-1:0] rd_done_o;
  logic               rd_err_o;
  logic [63:0]        rd_data_o;
  logic [GNT_W-1:0]   gnt_id_o;
  logic               busy_o;

  // Counter read-port side
  logic               ctr_req_o;
  logic               ctr_atomic_o;
  logic               ctr_ack_i;
  logic [31:0]        ctr_count_i;

  modport slave (
    input  rd_req_i, ctr_ack_i, ctr_count_i,
    output rd_done_o, rd_err_o, rd_data_o, gnt_id_o, busy_o, ctr_req_o, ctr_atomic_o
  );

  modport master (
    output rd_req_i, ctr_ack_i, ctr_count_i,
    input  rd_done_o, rd_err_o, rd_data_o, gnt_id_o, busy_o, ctr_req_o, ctr_atomic_o
  );
endinterface

// File: rtl/atomic_read_arbiter.sv
// Round-robin arbiter that serialises 64-bit reads of the event counter as an atomic lo beat
// followed by a hi beat, so beats from different requesters never interleave.
module atomic_read_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  atomic_read_arbiter_if.slave  bus
);

  localparam int GNT_W = $clog2(NUM_REQ);
  localparam logic [GNT_W:0]   NUM_REQ_W = (GNT_W+1)'(NUM_REQ);
  localparam logic [GNT_W-1:0] LAST_ID   = GNT_W'(NUM_REQ - 1);
  localparam logic [7:0]       TMO_LAST  = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ_LO,
    WAIT_LO,
    REQ_HI,
    WAIT_HI,
    RESP
  } state_t;

  state_t             state;
  logic [GNT_W-1:0]   rr_ptr;
  logic [GNT_W-1:0]   gnt_id;
  logic [7:0]         tmo_cnt;
  logic [31:0]        lo_word;

  logic [NUM_REQ-1:0] rd_done;
  logic               rd_err;
  logic [63:0]        rd_data;
  logic               busy;
  logic               ctr_req;
  logic               ctr_atomic;

  logic [GNT_W-1:0]   winner;
  logic [GNT_W:0]     probe;
  logic [GNT_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] gnt_onehot;

  // Lowest requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    winner = rr_ptr;
    probe  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      probe = {1'b0, rr_ptr} + (GNT_W+1)'(i);
      if (probe >= NUM_REQ_W) probe = probe - NUM_REQ_W;
      if (bus.rd_req_i[probe[GNT_W-1:0]]) winner = probe[GNT_W-1:0];
    end
  end

  assign next_ptr   = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
  assign gnt_onehot = NUM_REQ'(1) << gnt_id;

  // All outputs are registered and change on state transitions, so they line up with the state.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt_id     <= '0;
      tmo_cnt    <= '0;
      lo_word    <= '0;
      rd_done    <= '0;
      rd_err     <= 1'b0;
      rd_data    <= '0;
      busy       <= 1'b0;
      ctr_req    <= 1'b0;
      ctr_atomic <= 1'b0;
    end else begin
      rd_done <= '0;
      case (state)
        IDLE: begin
          if (|bus.rd_req_i) begin
            gnt_id     <= winner;
            state      <= REQ_LO;
            busy       <= 1'b1;
            ctr_req    <= 1'b1;
            ctr_atomic <= 1'b1;
          end
        end

        REQ_LO: begin
          ctr_req    <= 1'b0;
          ctr_atomic <= 1'b0;
          tmo_cnt    <= '0;
          state      <= WAIT_LO;
        end

        WAIT_LO: begin
          if (bus.ctr_ack_i) begin
            lo_word <= bus.ctr_count_i;
            ctr_req <= 1'b1;
            state   <= REQ_HI;
          end else if (tmo_cnt == TMO_LAST) begin
            rd_done <= gnt_onehot;
            rd_err  <= 1'b1;
            rd_data <= '0;
            state   <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        REQ_HI: begin
          ctr_req <= 1'b0;
          tmo_cnt <= '0;
          state   <= WAIT_HI;
        end

        WAIT_HI: begin
          if (bus.ctr_ack_i) begin
            rd_done <= gnt_onehot;
            rd_err  <= 1'b0;
            rd_data <= {bus.ctr_count_i, lo_word};
            state   <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            rd_done <= gnt_onehot;
            rd_err  <= 1'b1;
            rd_data <= '0;
            state   <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        RESP: begin
          // Pointer moves past the winner on every completion, errored or not.
          rd_err <= 1'b0;
          rr_ptr <= next_ptr;
          busy   <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          ctr_req    <= 1'b0;
          ctr_atomic <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_done_o    = rd_done;
  assign bus.rd_err_o     = rd_err;
  assign bus.rd_data_o    = rd_data;
  assign bus.gnt_id_o     = gnt_id;
  assign bus.busy_o       = busy;
  assign bus.ctr_req_o    = ctr_req;
  assign bus.ctr_atomic_o = ctr_atomic;

  a_done_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(rd_done));
  a_atomic_with_req: assert property (@(posedge clk) disable iff (!reset_n) ctr_atomic |-> ctr_req);

endmodule

// File: tb/tb_atomic_read_arbiter.sv
// Directed bench for atomic_read_arbiter: a vector table of whole transactions plus
// hand-written sequences for stray acks and a reset landing in WAIT_HI.
module tb_atomic_read_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ACK_TIMEOUT = 15;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  atomic_read_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  atomic_read_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Stimulus and counter-model state
  logic [3:0]  rd_req    = '0;
  logic        stray     = 1'b0;
  logic        load      = 1'b0;
  int          ack_delay = 1;
  logic [63:0] preload   = '0;
  logic [63:0] cnt       = '0;
  logic [31:0] m_data    = '0;
  logic [31:0] snap      = '0;
  logic        m_ack     = 1'b0;
  logic        armed     = 1'b0;
  int          cd        = 0;
  int          proto_err = 0;

  int          n_checks  = 0;
  int          n_errors  = 0;
  logic [63:0] last_data = '0;

  assign bus.rd_req_i    = rd_req;
  assign bus.ctr_ack_i   = m_ack | stray;
  assign bus.ctr_count_i = m_ack ? m_data : 32'hBAD0_BAD0;

  // 64-bit event counter, triggered every cycle; atomic beat returns lo and snapshots hi.
  always @(posedge clk) begin
    cnt   <= load ? preload : cnt + 64'd1;
    m_ack <= 1'b0;
    if (!reset_n) armed <= 1'b0;
    if (bus.ctr_req_o) begin
      if (bus.ctr_atomic_o) begin
        m_data <= cnt[31:0];
        snap   <= cnt[63:32];
        armed  <= 1'b1;
      end else begin
        m_data <= snap;
        if (!armed) proto_err <= proto_err + 1;
        armed  <= 1'b0;
      end
      if (ack_delay == 1) m_ack <= 1'b1;
      cd <= (ack_delay > 1) ? ack_delay - 1 : 0;
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1) m_ack <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  set;      // request bits raised at the start
    logic [3:0]  late;     // request bits raised two cycles in
    logic [3:0]  clr;      // request bits dropped after the done pulse
    int          dly;      // counter ack delay (0 = never)
    logic [63:0] pre;      // counter value at the atomic beat
    int          stray_k;  // cycle of an extra ack pulse (0 = none)
    int          gnt;
    int          lat;      // done cycle relative to the cycle the request is seen
    int          hi_k;     // cycle of the non-atomic beat (0 = none)
    logic        err;
    logic [63:0] data;
  } vec_t;

  vec_t vecs[17];

  task automatic run_vec(input vec_t v, input int idx);
    int   k;
    int   lo_k;
    int   hi_k;
    int   viol;
    logic busy1;
    logic seen;
    logic [3:0] exp_done;
    exp_done = 4'b0001 << v.gnt;
    @(negedge clk);
    check($sformatf("v%0d_idle_done", idx), 64'(bus.rd_done_o), 64'd0);
    check($sformatf("v%0d_hold_data", idx), bus.rd_data_o, last_data);
    rd_req    = rd_req | v.set;
    ack_delay = v.dly;
    preload   = v.pre;
    load      = 1'b1;
    k = 0; lo_k = 0; hi_k = 0; viol = 0; busy1 = 1'b0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      load  = 1'b0;
      stray = (k == v.stray_k);
      if (k == 2) rd_req = rd_req | v.late;
      if (k == 1) busy1 = bus.busy_o;
      if (bus.ctr_atomic_o && !bus.ctr_req_o) viol++;
      if (bus.ctr_req_o && bus.ctr_atomic_o && lo_k == 0) lo_k = k;
      if (bus.ctr_req_o && !bus.ctr_atomic_o && hi_k == 0) hi_k = k;
      if (bus.rd_done_o != 0) seen = 1'b1;
    end
    stray = 1'b0;
    check($sformatf("v%0d_done_seen", idx), 64'(seen), 64'd1);
    check($sformatf("v%0d_latency", idx), 64'(k), 64'(v.lat));
    check($sformatf("v%0d_busy", idx), 64'(busy1), 64'd1);
    check($sformatf("v%0d_lo_beat", idx), 64'(lo_k), 64'd1);
    check($sformatf("v%0d_hi_beat", idx), 64'(hi_k), 64'(v.hi_k));
    check($sformatf("v%0d_atomic_only_with_req", idx), 64'(viol), 64'd0);
    check($sformatf("v%0d_gnt", idx), 64'(bus.gnt_id_o), 64'(v.gnt));
    check($sformatf("v%0d_done", idx), 64'(bus.rd_done_o), 64'(exp_done));
    check($sformatf("v%0d_err", idx), 64'(bus.rd_err_o), 64'(v.err));
    check($sformatf("v%0d_data", idx), bus.rd_data_o, v.data);
    rd_req    = rd_req & ~v.clr;
    last_data = v.data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic seen;

    //            set      late     clr      dly pre                      stray gnt lat hi err data
    vecs[0]  = '{4'b1111, 4'b0000, 4'b0000, 1, 64'h0000_0000_0000_0010, 0, 0, 5,  3, 1'b0, 64'h0000_0000_0000_0010};
    vecs[1]  = '{4'b0000, 4'b0000, 4'b0000, 1, 64'h0000_0003_0000_0020, 0, 1, 5,  3, 1'b0, 64'h0000_0003_0000_0020};
    vecs[2]  = '{4'b0000, 4'b0000, 4'b0000, 1, 64'h0000_0004_0000_0030, 0, 2, 5,  3, 1'b0, 64'h0000_0004_0000_0030};
    vecs[3]  = '{4'b0000, 4'b0000, 4'b0000, 1, 64'h0000_0005_0000_0040, 0, 3, 5,  3, 1'b0, 64'h0000_0005_0000_0040};
    vecs[4]  = '{4'b0000, 4'b0000, 4'b1111, 1, 64'h0000_0006_0000_0050, 0, 0, 5,  3, 1'b0, 64'h0000_0006_0000_0050};
    vecs[5]  = '{4'b0001, 4'b0000, 4'b0001, 1, 64'h0000_0001_FFFF_FFFF, 0, 0, 5,  3, 1'b0, 64'h0000_0001_FFFF_FFFF};
    vecs[6]  = '{4'b0010, 4'b0000, 4'b0010, 1, 64'h1234_5678_9ABC_DEF0, 0, 1, 5,  3, 1'b0, 64'h1234_5678_9ABC_DEF0};
    vecs[7]  = '{4'b0101, 4'b0000, 4'b0100, 3, 64'hCAFE_F00D_8000_0001, 5, 2, 9,  5, 1'b0, 64'hCAFE_F00D_8000_0001};
    vecs[8]  = '{4'b0000, 4'b0000, 4'b0001, 1, 64'h0000_00FF_FFFF_FFFE, 0, 0, 5,  3, 1'b0, 64'h0000_00FF_FFFF_FFFE};
    vecs[9]  = '{4'b1000, 4'b0000, 4'b1000, 0, 64'hDEAD_BEEF_0BAD_F00D, 0, 3, 17, 0, 1'b1, 64'h0000_0000_0000_0000};
    vecs[10] = '{4'b1000, 4'b0000, 4'b1000, 1, 64'h7777_0000_0000_7777, 0, 3, 5,  3, 1'b0, 64'h7777_0000_0000_7777};
    vecs[11] = '{4'b0100, 4'b0000, 4'b0100, 1, 64'h0101_0101_0202_0202, 0, 2, 5,  3, 1'b0, 64'h0101_0101_0202_0202};
    vecs[12] = '{4'b1100, 4'b0001, 4'b1000, 1, 64'h8000_0000_0000_0000, 0, 3, 5,  3, 1'b0, 64'h8000_0000_0000_0000};
    vecs[13] = '{4'b0000, 4'b0000, 4'b0001, 1, 64'h0000_0000_FFFF_FFFF, 0, 0, 5,  3, 1'b0, 64'h0000_0000_FFFF_FFFF};
    vecs[14] = '{4'b0000, 4'b0000, 4'b0100, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 2, 5,  3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[15] = '{4'b1001, 4'b0000, 4'b0000, 1, 64'h0F0F_0F0F_F0F0_F0F0, 0, 3, 5,  3, 1'b0, 64'h0F0F_0F0F_F0F0_F0F0};
    vecs[16] = '{4'b0000, 4'b0000, 4'b1001, 1, 64'h1111_2222_3333_4444, 0, 0, 5,  3, 1'b0, 64'h1111_2222_3333_4444};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_done",   64'(bus.rd_done_o), 64'd0);
    check("rst_err",    64'(bus.rd_err_o), 64'd0);
    check("rst_data",   bus.rd_data_o, 64'd0);
    check("rst_gnt",    64'(bus.gnt_id_o), 64'd0);
    check("rst_busy",   64'(bus.busy_o), 64'd0);
    check("rst_req",    64'(bus.ctr_req_o), 64'd0);
    check("rst_atomic", 64'(bus.ctr_atomic_o), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

    // Stray ack while idle must not start anything or disturb held outputs
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    check("stray_idle_busy", 64'(bus.busy_o), 64'd0);
    check("stray_idle_req",  64'(bus.ctr_req_o), 64'd0);
    check("stray_idle_done", 64'(bus.rd_done_o), 64'd0);
    check("stray_idle_data", bus.rd_data_o, last_data);

    // Reset landing in WAIT_HI abandons the read; the held request restarts atomically
    rd_req    = 4'b0100;
    ack_delay = 1;
    preload   = 64'hAAAA_BBBB_CCCC_DDDD;
    load      = 1'b1;
    repeat (4) begin
      @(negedge clk);
      load = 1'b0;
    end
    check("pre_rst_busy", 64'(bus.busy_o), 64'd1);
    check("pre_rst_req",  64'(bus.ctr_req_o), 64'd0);
    check("pre_rst_gnt",  64'(bus.gnt_id_o), 64'd2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_done",   64'(bus.rd_done_o), 64'd0);
    check("mid_rst_err",    64'(bus.rd_err_o), 64'd0);
    check("mid_rst_data",   bus.rd_data_o, 64'd0);
    check("mid_rst_gnt",    64'(bus.gnt_id_o), 64'd0);
    check("mid_rst_busy",   64'(bus.busy_o), 64'd0);
    check("mid_rst_req",    64'(bus.ctr_req_o), 64'd0);
    check("mid_rst_atomic", 64'(bus.ctr_atomic_o), 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("in_rst_done%0d", i), 64'(bus.rd_done_o), 64'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    preload = 64'h0000_0009_1234_0000;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("restart_req",    64'(bus.ctr_req_o), 64'd1);
    check("restart_atomic", 64'(bus.ctr_atomic_o), 64'd1);
    k    = 1;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.rd_done_o != 0) seen = 1'b1;
    end
    check("restart_done_seen", 64'(seen), 64'd1);
    check("restart_latency",   64'(k), 64'd5);
    check("restart_gnt",       64'(bus.gnt_id_o), 64'd2);
    check("restart_done",      64'(bus.rd_done_o), 64'h4);
    check("restart_err",       64'(bus.rd_err_o), 64'd0);
    check("restart_data",      bus.rd_data_o, 64'h0000_0009_1234_0000);
    rd_req = 4'b0000;

    repeat (2) @(negedge clk);
    check("hi_beat_after_own_atomic", 64'(proto_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/atomic_read_arbiter.md
Name: atomic_read_arbiter

Overview:
- Shares the 32-bit read port of the 64-bit atomic event counter between NUM_REQ requesters.
- Each requester asks for a full 64-bit value. The arbiter issues the counter's two-beat sequence: first beat with atomic asserted (returns the low word and snapshots the upper word), second beat without it (returns the upper word).
- It then returns the assembled 64-bit value to the granted requester.
- Beats from different requesters are never interleaved, so every 64-bit read stays single-copy atomic.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ACK_TIMEOUT, 15, cycles to wait for ctr_ack_i per beat before aborting (1..255).

Ports:
- clk  input  1  clock, all flops posedge.
- reset_n  input  1  asynchronous active-low reset.
- rd_req_i  input  NUM_REQ  per-requester level request; held until the matching rd_done_o pulse.
- rd_done_o  output  NUM_REQ  one-hot, one-cycle completion pulse to the granted requester.
- rd_err_o  output  1  valid with rd_done_o; 1 means the transaction was aborted on timeout.
- rd_data_o  output  64  assembled value {hi,lo}; valid while any rd_done_o bit is set.
- gnt_id_o  output  clog2(NUM_REQ)  index of the current or last granted requester.
- busy_o  output  1  high in every state except IDLE.
- ctr_req_o  output  1  request to the counter.
- ctr_atomic_o  output  1  marks the first beat; only meaningful while ctr_req_o=1, otherwise 0.
- ctr_ack_i  input  1  acknowledge from the counter (nominally 1 cycle after ctr_req_o).
- ctr_count_i  input  32  counter data, sampled when ctr_ack_i=1.

Behaviour:
- Reset (async assert, sync deassert by the system): state=IDLE. All outputs 0: rd_done_o, rd_err_o, rd_data_o, gnt_id_o, busy_o, ctr_req_o, ctr_atomic_o. RR pointer=0, timeout counter=0. A reset mid-transaction abandons it with no done pulse.
- FSM states: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, RESP.
- IDLE:
  - If rd_req_i != 0, pick a winner round-robin, latch it into gnt_id_o, go to REQ_LO.
  - Otherwise stay in IDLE.
- REQ_LO: ctr_req_o=1 and ctr_atomic_o=1 for exactly one cycle; clear the timeout counter; go to WAIT_LO.
- WAIT_LO: ctr_req_o=0.
  - On ctr_ack_i, capture lo=ctr_count_i and go to REQ_HI.
  - Else increment the timeout counter; on reaching ACK_TIMEOUT, set err and go to RESP.
- REQ_HI: ctr_req_o=1 and ctr_atomic_o=0 for one cycle; clear the timeout counter; go to WAIT_HI.
- WAIT_HI: same rules as WAIT_LO, but captures hi.
- RESP (one cycle):
  - rd_done_o[gnt_id]=1, rd_data_o={hi,lo}, rd_err_o=err.
  - On error, rd_data_o=0.
  - Clear err; RR pointer = (gnt_id+1) mod NUM_REQ; go to IDLE.
- Latency with a 1-cycle counter ack: request seen in IDLE at cycle T, ctr_req_o at T+1 and T+3, rd_done_o at T+5. Minimum of 6 cycles per read with continuous demand.
- Round-robin: search starts at the RR pointer and wraps modulo NUM_REQ; the lowest index at or after the pointer wins.
  - The pointer advances only on completion, including errored completion.
  - A requester cannot win twice in a row while another requester is pending.
- Requests are sampled only in IDLE. A request that rises during a transaction waits.
- A requester that drops rd_req_i mid-transaction does not abort it; the done pulse is still issued.
- A requester whose request is still high in the cycle after its done pulse is treated as a new request.
- ctr_ack_i outside WAIT_LO/WAIT_HI is ignored, has no state change, and is not captured.
- Any number of trigger increments between beats is irrelevant: the counter's atomic snapshot guarantees consistency. The arbiter must never issue a non-atomic beat that is not preceded by its own atomic beat.
- rd_data_o holds its last value outside RESP (0 after an error). gnt_id_o holds until the next grant.

Test Plan:
1. Single requester, counter preloaded to 0x0000_0001_FFFF_FFFF, trigger on every cycle.
   -> ctr_req_o at T+1 (atomic=1) and T+3 (atomic=0); rd_done_o=0001 at T+5; rd_data_o equals the counter value at the atomic beat, with upper=1 even though the counter's upper word has since wrapped to 2.
2. All four requesters assert rd_req_i=1111 together and hold.
   -> grants in order 0,1,2,3,0; done pulses 6 cycles apart; rd_err_o=0 throughout.
3. Requesters 2 and 3 pending with the RR pointer at 3.
   -> 3 is granted first, then 2; when requester 0 rises mid-transaction, it is served after 3 and before 2.
4. Counter model never acks.
   -> after ACK_TIMEOUT=15 idle cycles in WAIT_LO: rd_done_o pulse, rd_err_o=1, rd_data_o=0; no REQ_HI beat issued; next request proceeds normally.
5. Stray ctr_ack_i in IDLE and REQ_HI, plus a counter ack delayed to 3 cycles.
   -> stray acks ignored; delayed ack accepted; data correct; done 4 cycles later than nominal.
6. reset_n asserted in WAIT_HI.
   -> all outputs 0 immediately (async); no done pulse; after release, a held request restarts from REQ_LO with a fresh atomic beat.
